controller_pio_irq_in: RTL and testbench

Parametrised, multi-channel Avalon-MM input PIO with per-bit edge selection, write-1-to-clear edge capture and a maskable level interrupt. It sits on the controller's Avalon bus as a slave, next to the other PIO slaves, and collects asynchronous board inputs (switches, sensor flags, fault lines) into a single IRQ source. An optional per-channel debounce filter is compiled in with a macro.

---
 rtl/controller_pio_irq_in.sv | 156 +++++++++++++++
 tb/tb_controller_pio_irq_in.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller_pio_irq_in.sv
// controller_pio_irq_in: Avalon-MM input PIO with per-bit rise/fall edge capture
// (write-1-to-clear) and a maskable level interrupt.
// Latency: input to edge_capture/irq is SYNC_STAGES+1 clk edges; readdata is 1 cycle.
// Backpressure: none. The slave accepts every access with zero wait states.
// Optional debounce filter: define CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN.

module controller_pio_irq_in #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_W    = 16,
  parameter int DEBOUNCE_INIT = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_RISE  = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE  = 3'd3;
  localparam logic [2:0] ADDR_FALL  = 3'd4;
  localparam logic [2:0] ADDR_DBLEN = 3'd5;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_prev;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] wr_dat;
  logic             wr_en;
  logic [31:0]      rd_mux;

  // Upper writedata bits have no register behind them.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en  = chipselect & ~write_n;
  assign wr_dat = writedata[WIDTH-1:0];

  // Metastability synchroniser: shift each input through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] debounce_len;
  logic [DEBOUNCE_W-1:0] db_cnt [WIDTH];
  logic [WIDTH-1:0]      c_q;

  // Debounce length register; a shorter value takes effect immediately via >=.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounce_len <= DEBOUNCE_W'(DEBOUNCE_INIT);
    end else if (wr_en && address == ADDR_DBLEN) begin
      debounce_len <= writedata[DEBOUNCE_W-1:0];
    end
  end

  // Per-channel filter: c follows s only after s has disagreed for debounce_len+1 cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == c_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= debounce_len) begin
          c_q[i]    <= s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign c = c_q;
`else
  assign c = s;
`endif

  // Previous conditioned value for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) c_prev <= '0;
    else          c_prev <= c;
  end

  assign hit = (c & ~c_prev & rise_en) | (~c & c_prev & fall_en);

  // Control registers written from the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en  <= '1;
      fall_en  <= '0;
      irq_mask <= '0;
    end else if (wr_en) begin
      if (address == ADDR_RISE) rise_en  <= wr_dat;
      if (address == ADDR_MASK) irq_mask <= wr_dat;
      if (address == ADDR_FALL) fall_en  <= wr_dat;
    end
  end

  // Edge capture: W1C clear, with a same-cycle hit overriding the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else if (wr_en && address == ADDR_EDGE) begin
      edge_capture <= (edge_capture & ~wr_dat) | hit;
    end else begin
      edge_capture <= edge_capture | hit;
    end
  end

  // Read mux from the current address, zero-extended.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = c;
      ADDR_RISE: rd_mux[WIDTH-1:0] = rise_en;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      ADDR_FALL: rd_mux[WIDTH-1:0] = fall_en;
`ifdef CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN
      ADDR_DBLEN: rd_mux[DEBOUNCE_W-1:0] = debounce_len;
`endif
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_controller_pio_irq_in.sv
// Bench for controller_pio_irq_in: directed scenarios with literal expectations,
// then randomized traffic; a queue-based reference model is compared every cycle.
module tb_controller_pio_irq_in;

  localparam int W = 8;
  localparam int S = 2;
`ifdef CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 0;
  logic          reset_n = 0;
  logic [2:0]    address = 0;
  logic          chipselect = 0;
  logic          write_n = 1;
  logic [31:0]   writedata = 0;
  logic [W-1:0]  in_port = 0;
  logic [31:0]   readdata;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  controller_pio_irq_in #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_W(16), .DEBOUNCE_INIT(100)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] hist[$];
  logic [W-1:0] m_s, m_c, m_cp, m_ec, m_rise, m_fall, m_mask;
  logic [15:0]  m_len;
  int           m_run [W];
  logic [31:0]  m_rd;
  logic         m_irq;

  always @(posedge clk or negedge reset_n) begin : model
    logic [W-1:0] hit_v, nc, ns, clr;
    logic [31:0]  rd;
    logic         wr;
    if (!reset_n) begin
      hist.delete();
      m_s = 0; m_c = 0; m_cp = 0; m_ec = 0;
      m_rise = '1; m_fall = 0; m_mask = 0; m_len = 16'd100; m_rd = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      hit_v = (m_c & ~m_cp & m_rise) | (~m_c & m_cp & m_fall);
      wr = chipselect && !write_n;
      rd = 0;
      case (address)
        3'd0: rd[W-1:0] = m_c;
        3'd1: rd[W-1:0] = m_rise;
        3'd2: rd[W-1:0] = m_mask;
        3'd3: rd[W-1:0] = m_ec;
        3'd4: rd[W-1:0] = m_fall;
`ifdef CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN
        3'd5: rd[15:0] = m_len;
`endif
        default: rd = 0;
      endcase
      // s is the input value sampled S-1 edges before this one.
      hist.push_front(in_port);
      if (hist.size() > S) void'(hist.pop_back());
      ns = (hist.size() == S) ? hist[S-1] : '0;
`ifdef CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN
      // c adopts s once s has disagreed with it for more than m_len cycles.
      nc = m_c;
      for (int i = 0; i < W; i++) begin
        if (m_s[i] != m_c[i]) begin
          if (m_run[i] >= int'(m_len)) begin nc[i] = m_s[i]; m_run[i] = 0; end
          else m_run[i]++;
        end else m_run[i] = 0;
      end
`else
      nc = ns;
`endif
      m_cp = m_c; m_c = nc; m_s = ns;
      clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
      m_ec = (m_ec & ~clr) | hit_v;
      if (wr) begin
        if (address == 3'd1) m_rise = writedata[W-1:0];
        if (address == 3'd2) m_mask = writedata[W-1:0];
        if (address == 3'd4) m_fall = writedata[W-1:0];
`ifdef CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN
        if (address == 3'd5) m_len = writedata[15:0];
`endif
      end
      m_rd = rd;
    end
  end

  assign m_irq = |(m_ec & m_mask);

  // Continuous comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("readdata", readdata, m_rd);
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk); chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk); address = a; chipselect = 1; write_n = 1;
    @(negedge clk); v = readdata; chipselect = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1; chk_on = 1;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    rd(3'd1, v); chk("reset_rise_en", v, 32'h0000_00FF);
    rd(3'd4, v); chk("reset_fall_en", v, 32'h0);
    rd(3'd3, v); chk("reset_edge_capture", v, 32'h0);
`ifdef CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN
    rd(3'd5, v); chk("reset_debounce_len", v, 32'd100);
    wr(3'd5, 32'd0);
`endif

    // Rising edge on bit 0: irq rises exactly at edge S (plus filter latency).
    wr(3'd2, 32'h01);
    in_port = 8'h01;
    for (int k = 0; k <= S + EXTRA; k++) begin
      @(negedge clk);
      chk("rise_irq_timing", {31'b0, irq}, (k == S + EXTRA) ? 32'h1 : 32'h0);
    end
    rd(3'd3, v); chk("rise_capture", v, 32'h01);
    wr(3'd3, 32'h01);
    chk("rise_irq_cleared", {31'b0, irq}, 32'h0);

    // Falling-edge select on bit 7.
    wr(3'd1, 32'h00); wr(3'd4, 32'h80); wr(3'd2, 32'h80);
    in_port = 8'h81; wait_cyc(S + 6);
    rd(3'd3, v); chk("fall_no_rise_capture", v, 32'h0);
    in_port = 8'h01; wait_cyc(S + 6);
    rd(3'd3, v); chk("fall_capture", v, 32'h80);
    chk("fall_irq", {31'b0, irq}, 32'h1);
    wr(3'd3, 32'h80);
    in_port = 8'h81; wait_cyc(S + 6);
    rd(3'd3, v); chk("fall_ignore_rise", v, 32'h0);

    // Partial clear and set-wins collision.
    wr(3'd4, 32'h00); wr(3'd1, 32'h03);
    in_port = 8'h80; wait_cyc(S + 6);
    wr(3'd3, 32'hFF);
    in_port = 8'h83; wait_cyc(S + 6);
    rd(3'd3, v); chk("both_captured", v, 32'h03);
    wr(3'd3, 32'h01);
    rd(3'd3, v); chk("partial_clear", v, 32'h02);
    in_port = 8'h81; wait_cyc(S + 6);
    rd(3'd3, v); chk("no_capture_on_fall", v, 32'h02);
    @(negedge clk); in_port = 8'h83;
    repeat (S + EXTRA) @(negedge clk);
    address = 3'd3; writedata = 32'h02; chipselect = 1; write_n = 0;
    @(negedge clk); chipselect = 0; write_n = 1;
    rd(3'd3, v); chk("collision_set_wins", v, 32'h02);

`ifdef CONTROLLER_PIO_IRQ_IN_DEBOUNCE_EN
    // Debounce with length 4: short pulse filtered, long pulse captured.
    wr(3'd5, 32'd4); wr(3'd1, 32'h04); wr(3'd3, 32'hFF);
    @(negedge clk); in_port = 8'h87; wait_cyc(3); in_port = 8'h83; wait_cyc(12);
    rd(3'd3, v); chk("debounce_short_pulse", v & 32'h4, 32'h0);
    rd(3'd0, v); chk("debounce_short_data", v & 32'h4, 32'h0);
    @(negedge clk); in_port = 8'h87; wait_cyc(6); in_port = 8'h83; wait_cyc(14);
    rd(3'd3, v); chk("debounce_long_pulse", v & 32'h4, 32'h4);
    wr(3'd1, 32'h03); wr(3'd3, 32'hFF);
    @(negedge clk); in_port = 8'h81; wait_cyc(14);
    @(negedge clk); in_port = 8'h83;
    wait_cyc(S + 5);
    rd(3'd3, v); chk("debounce_relatch", v, 32'h02);
`endif

    // Asynchronous reset mid-operation with irq asserted.
    wr(3'd2, 32'h02);
    @(negedge clk); address = 3'd3;
    @(negedge clk);
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);
    chk("pre_reset_readdata", readdata, 32'h02);
    @(posedge clk); #2; reset_n = 0; #1;
    chk("async_reset_irq", {31'b0, irq}, 32'h0);
    chk("async_reset_readdata", readdata, 32'h0);
    in_port = 8'h00;
    @(negedge clk); @(negedge clk); reset_n = 1;
    rd(3'd1, v); chk("post_reset_rise_en", v, 32'hFF);
    rd(3'd2, v); chk("post_reset_mask", v, 32'h0);
    rd(3'd3, v); chk("post_reset_capture", v, 32'h0);
    rd(3'd4, v); chk("post_reset_fall_en", v, 32'h0);
    rd(3'd6, v); chk("unmapped_addr", v, 32'h0);

    // Randomized traffic; the negedge comparator checks every cycle.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = (address == 3'd5) ? 32'($urandom_range(0, 5)) : $urandom;
    end
    @(negedge clk); chipselect = 0; write_n = 1;
    wait_cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
